// File: rtl/cmp_seq_ctrl_pkg.sv
// Shared constants for the sliced magnitude-compare sequencer:
// state encodings, slice width and the {gt,eq,lt} flag encodings.
package cmp_seq_pkg;

  localparam int SLICE_W = 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

endpackage

// File: rtl/cmp_seq_ctrl_comparator.sv
// Existing 2-bit unsigned magnitude comparator, shared by the sequencer.
module comparator (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic       A_gt_B,
  output logic       A_eq_B,
  output logic       A_lt_B
);

  assign A_gt_B = (A > B);
  assign A_eq_B = (A == B);
  assign A_lt_B = (A < B);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Wide unsigned compare done one 2-bit slice per clock, MSB slice first,
// stopping at the first unequal slice; one shared 2-bit comparator.
module cmp_seq_ctrl
  import cmp_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
      $error("cmp_seq_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  logic [0:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [IDXW-1:0]  idx;
  logic [2:0]       flags;

  logic [WIDTH-1:0] opa_shift;
  logic [WIDTH-1:0] opb_shift;
  logic [1:0]       slice_a;
  logic [1:0]       slice_b;
  logic             slice_gt;
  logic             slice_eq;
  logic             slice_lt;

  // Shift the current slice down to bit 0 instead of a variable part-select.
  assign opa_shift = opa >> {idx, 1'b0};
  assign opb_shift = opb >> {idx, 1'b0};
  assign slice_a   = opa_shift[SLICE_W-1:0];
  assign slice_b   = opb_shift[SLICE_W-1:0];

  comparator u_comparator (
    .A      (slice_a),
    .B      (slice_b),
    .A_gt_B (slice_gt),
    .A_eq_B (slice_eq),
    .A_lt_B (slice_lt)
  );

  assign busy   = (state == RUN);
  assign a_gt_b = flags[2];
  assign a_eq_b = flags[1];
  assign a_lt_b = flags[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      idx   <= '0;
      flags <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            idx   <= IDXW'(NSLICE - 1);
            state <= RUN;
          end
        end
        RUN: begin
          // Abort wins over completion and leaves the previous flags intact.
          if (abort) begin
            state <= IDLE;
          end else if (!slice_eq) begin
            flags <= {slice_gt, slice_eq, slice_lt};
            done  <= 1'b1;
            state <= IDLE;
          end else if (idx == '0) begin
            flags <= EQ;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Self-checking bench for cmp_seq_ctrl: directed plan steps plus randomized
// compares checked against an arithmetic reference model.
module tb_cmp_seq_ctrl;

  localparam int WIDTH  = 8;
  localparam int NSLICE = WIDTH / 2;
  localparam int MAXCYC = 20;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;

  int checks;
  int failures;

  cmp_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .a_lt_b (a_lt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] curFlags();
    return {a_gt_b, a_eq_b, a_lt_b};
  endfunction

  // Reference: unsigned compare, latency = slices scanned from MSB down to first difference.
  function automatic void modelCompare(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                       output logic [2:0] flags, output int k);
    int  xs;
    int  ys;
    bit  found;
    flags = (x > y) ? 3'b100 : ((x < y) ? 3'b001 : 3'b010);
    k     = NSLICE;
    found = 1'b0;
    for (int s = NSLICE - 1; s >= 0; s--) begin
      xs = (int'(x) / (4 ** s)) % 4;
      ys = (int'(y) / (4 ** s)) % 4;
      if (!found && xs != ys) begin
        k     = NSLICE - s;
        found = 1'b1;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge where the DUT is idle (or in its done cycle); returns at the done negedge.
  task automatic runCompare(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [2:0] expFlags;
    int         expK;
    int         cycles;
    modelCompare(x, y, expFlags, expK);
    applyStimulus(x, y);
    checkOutput({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
    cycles = 0;
    while (!done && cycles < MAXCYC) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, expK);
    checkOutput({tag, "_flags"}, 32'(curFlags()), 32'(expFlags));
    checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int               cycles;
    int               doneCount;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    a        = '0;
    b        = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_flags", 32'(curFlags()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_flags_before_completion", 32'(curFlags()), 32'd0);

    $display("[TB] step 1: MSB slice decides");
    runCompare("s1", 8'hA5, 8'h35);
    @(negedge clk);
    checkOutput("s1_done_one_cycle", 32'(done), 32'd0);

    $display("[TB] step 2: equal operands");
    runCompare("s2", 8'h3C, 8'h3C);
    @(negedge clk);

    $display("[TB] step 3: LSB slice decides, then back-to-back start");
    runCompare("s3a", 8'h34, 8'h36);
    runCompare("s3b", 8'hFF, 8'h00);
    @(negedge clk);
    checkOutput("s3b_done_dropped", 32'(done), 32'd0);

    $display("[TB] step 4: start while busy is ignored");
    applyStimulus(8'h10, 8'h10);
    start = 1'b1;
    a     = 8'h00;
    b     = 8'hFF;
    @(negedge clk);
    start     = 1'b0;
    cycles    = 1;
    doneCount = 0;
    while (!done && cycles < MAXCYC) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("s4_latency", cycles, 4);
    checkOutput("s4_flags", 32'(curFlags()), 32'b010);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("s4_single_done", doneCount, 0);
    checkOutput("s4_idle_after", 32'(busy), 32'd0);

    $display("[TB] step 5: abort on second RUN edge");
    runCompare("s5_prior", 8'hC0, 8'h40);
    @(negedge clk);
    applyStimulus(8'h01, 8'h02);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("s5_busy_after_abort", 32'(busy), 32'd0);
    checkOutput("s5_no_done", 32'(done), 32'd0);
    checkOutput("s5_flags_held", 32'(curFlags()), 32'b100);
    doneCount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("s5_no_late_done", doneCount, 0);
    checkOutput("s5_flags_still_held", 32'(curFlags()), 32'b100);

    $display("[TB] step 6: async reset mid-compare");
    applyStimulus(8'h00, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6_busy_reset", 32'(busy), 32'd0);
    checkOutput("s6_done_reset", 32'(done), 32'd0);
    checkOutput("s6_flags_reset", 32'(curFlags()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("s6_no_done_after_release", 32'(done), 32'd0);
    runCompare("s6_restart", 8'h02, 8'h02);
    @(negedge clk);

    $display("[TB] random compares against reference model");
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ WIDTH'($urandom_range(1, 3));
        2:       rb = ra ^ (WIDTH'($urandom_range(1, 3)) << 2 * $urandom_range(0, NSLICE - 1));
        default: rb = WIDTH'($urandom);
      endcase
      runCompare($sformatf("rand%0d", i), ra, rb);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
